// File: rtl/alu_station.sv
// alu_station: single-entry ALU reservation station with broadcast snoop and registered writeback.
// Optional feature macro ALU_SELF_FWD_EN: own wb_* output becomes a lowest-priority snoop source.
module alu_station #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned REG_W        = 5,
  parameter int unsigned TAG_W        = 3,
  parameter int unsigned OP_W         = 4,
  parameter int unsigned UNLOCKED_TAG = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             en_in,
  input  logic [XLEN-1:0]  pc_in,
  input  logic [OP_W-1:0]  op_in,
  input  logic [TAG_W-1:0] tagx_in,
  input  logic [TAG_W-1:0] tagy_in,
  input  logic [TAG_W-1:0] tagw_in,
  input  logic [XLEN-1:0]  datax_in,
  input  logic [XLEN-1:0]  datay_in,
  input  logic [REG_W-1:0] addrx_in,
  input  logic [REG_W-1:0] addry_in,
  input  logic [REG_W-1:0] addrw_in,
  input  logic             en_mw0,
  input  logic             en_mw1,
  input  logic             en_mw2,
  input  logic [REG_W-1:0] waddr0,
  input  logic [REG_W-1:0] waddr1,
  input  logic [REG_W-1:0] waddr2,
  input  logic [XLEN-1:0]  wdata0,
  input  logic [XLEN-1:0]  wdata1,
  input  logic [XLEN-1:0]  wdata2,
  output logic             busy_out,
  output logic [TAG_W-1:0] tagx_out,
  output logic [TAG_W-1:0] tagy_out,
  output logic [TAG_W-1:0] tagw_out,
  output logic             wb_en_out,
  output logic [REG_W-1:0] wb_addr_out,
  output logic [XLEN-1:0]  wb_data_out
);

  localparam logic [TAG_W-1:0] L_UNL = TAG_W'(UNLOCKED_TAG);

  typedef enum logic {S_EMPTY, S_WAIT} state_t;

  state_t           r_state;
  logic [OP_W-1:0]  r_op;
  logic [XLEN-1:0]  r_pc, r_datax, r_datay;
  logic [TAG_W-1:0] r_tagx, r_tagy, r_tagw;
  logic [REG_W-1:0] r_addrx, r_addry, r_addrw;
  logic             r_wb_en;
  logic [REG_W-1:0] r_wb_addr;
  logic [XLEN-1:0]  r_wb_data;

  logic             w_fire;
  logic [XLEN-1:0]  w_result;
  logic [4:0]       w_shamt;
  logic [TAG_W-1:0] w_bx_tag, w_by_tag, w_bw_tag, w_nx_tag, w_ny_tag, w_nw_tag;
  logic [XLEN-1:0]  w_bx_data, w_by_data, w_nx_data, w_ny_data;
  logic [REG_W-1:0] w_bx_addr, w_by_addr, w_bw_addr;

  function automatic logic src_hit(input logic [REG_W-1:0] a);
    logic h;
    h = (en_mw0 && waddr0 == a) || (en_mw1 && waddr1 == a) || (en_mw2 && waddr2 == a);
`ifdef ALU_SELF_FWD_EN
    h = h || (r_wb_en && r_wb_addr == a);
`endif
    return h && (a != '0);
  endfunction

  // Priority chain: mw0 > mw1 > mw2 (> own writeback when self-forwarding).
  function automatic logic [XLEN-1:0] src_data(input logic [REG_W-1:0] a);
    logic [XLEN-1:0] d;
    d = '0;
    if (en_mw0 && waddr0 == a)      d = wdata0;
    else if (en_mw1 && waddr1 == a) d = wdata1;
    else if (en_mw2 && waddr2 == a) d = wdata2;
`ifdef ALU_SELF_FWD_EN
    else if (r_wb_en && r_wb_addr == a) d = r_wb_data;
`endif
    return d;
  endfunction

  assign w_fire = (r_state == S_WAIT) && (r_tagx == L_UNL) && (r_tagy == L_UNL) && (r_tagw == L_UNL);

  // Accept snoops the incoming operands; otherwise the held entry is snooped.
  always_comb begin
    w_bx_tag  = en_in ? tagx_in  : r_tagx;
    w_by_tag  = en_in ? tagy_in  : r_tagy;
    w_bw_tag  = en_in ? tagw_in  : r_tagw;
    w_bx_data = en_in ? datax_in : r_datax;
    w_by_data = en_in ? datay_in : r_datay;
    w_bx_addr = en_in ? addrx_in : r_addrx;
    w_by_addr = en_in ? addry_in : r_addry;
    w_bw_addr = en_in ? addrw_in : r_addrw;
    w_nx_tag  = w_bx_tag;
    w_ny_tag  = w_by_tag;
    w_nw_tag  = w_bw_tag;
    w_nx_data = w_bx_data;
    w_ny_data = w_by_data;
    if (w_bx_tag != L_UNL && src_hit(w_bx_addr)) begin
      w_nx_tag  = L_UNL;
      w_nx_data = src_data(w_bx_addr);
    end
    if (w_by_tag != L_UNL && src_hit(w_by_addr)) begin
      w_ny_tag  = L_UNL;
      w_ny_data = src_data(w_by_addr);
    end
    if (w_bw_tag != L_UNL && src_hit(w_bw_addr)) w_nw_tag = L_UNL;
  end

  assign w_shamt = r_datay[4:0];

  always_comb begin
    w_result = '0;
    case (32'(r_op))
      0:  w_result = r_datax + r_datay;
      1:  w_result = r_datax - r_datay;
      2:  w_result = r_datax << w_shamt;
      3:  w_result = {{(XLEN-1){1'b0}}, ($signed(r_datax) < $signed(r_datay))};
      4:  w_result = {{(XLEN-1){1'b0}}, (r_datax < r_datay)};
      5:  w_result = r_datax ^ r_datay;
      6:  w_result = r_datax >> w_shamt;
      7:  w_result = $signed(r_datax) >>> w_shamt;
      8:  w_result = r_datax | r_datay;
      9:  w_result = r_datax & r_datay;
      10: w_result = r_datay;
      11: w_result = r_pc + r_datay;
      12: w_result = r_pc + XLEN'(4);
      default: w_result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_EMPTY;
      r_op      <= '0;
      r_pc      <= '0;
      r_datax   <= '0;
      r_datay   <= '0;
      r_tagx    <= L_UNL;
      r_tagy    <= L_UNL;
      r_tagw    <= L_UNL;
      r_addrx   <= '0;
      r_addry   <= '0;
      r_addrw   <= '0;
      r_wb_en   <= 1'b0;
      r_wb_addr <= '0;
      r_wb_data <= '0;
    end else if (rdy) begin
      r_wb_en <= w_fire && (r_addrw != '0);
      if (w_fire) begin
        r_wb_addr <= r_addrw;
        r_wb_data <= w_result;
      end
      if (en_in) begin
        r_op    <= op_in;
        r_pc    <= pc_in;
        r_addrx <= addrx_in;
        r_addry <= addry_in;
        r_addrw <= addrw_in;
      end
      if (en_in || r_state == S_WAIT) begin
        r_tagx  <= w_nx_tag;
        r_tagy  <= w_ny_tag;
        r_tagw  <= w_nw_tag;
        r_datax <= w_nx_data;
        r_datay <= w_ny_data;
      end
      if (en_in)       r_state <= S_WAIT;
      else if (w_fire) r_state <= S_EMPTY;
    end else begin
      r_wb_en <= 1'b0;
    end
  end

  a_issue_while_waiting: assert property (@(posedge clk) disable iff (!rst)
    (rdy && en_in && r_state == S_WAIT) |-> w_fire);

  assign busy_out    = (r_state == S_WAIT);
  assign tagx_out    = r_tagx;
  assign tagy_out    = r_tagy;
  assign tagw_out    = r_tagw;
  assign wb_en_out   = r_wb_en;
  assign wb_addr_out = r_wb_addr;
  assign wb_data_out = r_wb_data;

endmodule

// File: tb/tb_alu_station.sv
// tb_alu_station: directed vectors, corner sequences and a randomized run against a reference model.
module tb_alu_station;
  logic        clk, rst, rdy, en_in;
  logic [31:0] pc_in;
  logic [3:0]  op_in;
  logic [2:0]  tagx_in, tagy_in, tagw_in;
  logic [31:0] datax_in, datay_in;
  logic [4:0]  addrx_in, addry_in, addrw_in;
  logic        en_mw0, en_mw1, en_mw2;
  logic [4:0]  waddr0, waddr1, waddr2;
  logic [31:0] wdata0, wdata1, wdata2;
  logic        busy_out;
  logic [2:0]  tagx_out, tagy_out, tagw_out;
  logic        wb_en_out;
  logic [4:0]  wb_addr_out;
  logic [31:0] wb_data_out;

  int n_checks, n_errors;

  alu_station #(.XLEN(32), .REG_W(5), .TAG_W(3), .OP_W(4), .UNLOCKED_TAG(0)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .en_in(en_in), .pc_in(pc_in), .op_in(op_in),
    .tagx_in(tagx_in), .tagy_in(tagy_in), .tagw_in(tagw_in),
    .datax_in(datax_in), .datay_in(datay_in),
    .addrx_in(addrx_in), .addry_in(addry_in), .addrw_in(addrw_in),
    .en_mw0(en_mw0), .en_mw1(en_mw1), .en_mw2(en_mw2),
    .waddr0(waddr0), .waddr1(waddr1), .waddr2(waddr2),
    .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
    .busy_out(busy_out), .tagx_out(tagx_out), .tagy_out(tagy_out), .tagw_out(tagw_out),
    .wb_en_out(wb_en_out), .wb_addr_out(wb_addr_out), .wb_data_out(wb_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] pc, x, y, exp;
    logic [4:0]  aw;
  } vec_t;
  vec_t vecs[18];

  // reference model state
  bit          m_busy;
  logic [2:0]  m_tag[3];
  logic [31:0] m_val[2];
  logic [4:0]  m_addr[3];
  logic [3:0]  m_op;
  logic [31:0] m_pc;
  bit          m_wb_en;
  logic [4:0]  m_wb_addr;
  logic [31:0] m_wb_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en_in = 1'b0; rdy = 1'b1; pc_in = '0; op_in = '0;
    tagx_in = '0; tagy_in = '0; tagw_in = '0; datax_in = '0; datay_in = '0;
    addrx_in = '0; addry_in = '0; addrw_in = '0;
    en_mw0 = 1'b0; en_mw1 = 1'b0; en_mw2 = 1'b0;
    waddr0 = '0; waddr1 = '0; waddr2 = '0; wdata0 = '0; wdata1 = '0; wdata2 = '0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] pc, input logic [31:0] x,
                       input logic [31:0] y, input logic [2:0] tx, input logic [2:0] ty,
                       input logic [2:0] tw, input logic [4:0] ax, input logic [4:0] ay,
                       input logic [4:0] aw);
    en_in = 1'b1; op_in = op; pc_in = pc; datax_in = x; datay_in = y;
    tagx_in = tx; tagy_in = ty; tagw_in = tw; addrx_in = ax; addry_in = ay; addrw_in = aw;
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] pc,
                                          input logic [31:0] x, input logic [31:0] y);
    logic signed [31:0] sx, sy;
    int unsigned sh;
    sx = x; sy = y; sh = int'(y[4:0]);
    case (op)
      4'd0:  return x + y;
      4'd1:  return x - y;
      4'd2:  return x << sh;
      4'd3:  return (sx < sy) ? 32'd1 : 32'd0;
      4'd4:  return (x < y) ? 32'd1 : 32'd0;
      4'd5:  return x ^ y;
      4'd6:  return x >> sh;
      4'd7:  return sx >>> sh;
      4'd8:  return x | y;
      4'd9:  return x & y;
      4'd10: return y;
      4'd11: return pc + y;
      4'd12: return pc + 32'd4;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_busy = 0; m_op = '0; m_pc = '0; m_wb_en = 0; m_wb_addr = '0; m_wb_data = '0;
    for (int k = 0; k < 3; k++) begin m_tag[k] = '0; m_addr[k] = '0; end
    m_val[0] = '0; m_val[1] = '0;
  endtask

  // Advances the model by one clock using the inputs currently driven.
  task automatic model_step();
    logic        s_en[4];
    logic [4:0]  s_a[4];
    logic [31:0] s_d[4];
    int          ns;
    bit          fire;
    s_en[0] = en_mw0; s_a[0] = waddr0; s_d[0] = wdata0;
    s_en[1] = en_mw1; s_a[1] = waddr1; s_d[1] = wdata1;
    s_en[2] = en_mw2; s_a[2] = waddr2; s_d[2] = wdata2;
    s_en[3] = 1'b0;   s_a[3] = '0;     s_d[3] = '0;
    ns = 3;
`ifdef ALU_SELF_FWD_EN
    s_en[3] = m_wb_en; s_a[3] = m_wb_addr; s_d[3] = m_wb_data; ns = 4;
`endif
    if (!rdy) begin
      m_wb_en = 0;
      return;
    end
    fire = m_busy && m_tag[0] == '0 && m_tag[1] == '0 && m_tag[2] == '0;
    m_wb_en = fire && (m_addr[2] != '0);
    if (fire) begin
      m_wb_addr = m_addr[2];
      m_wb_data = ref_alu(m_op, m_pc, m_val[0], m_val[1]);
    end
    if (en_in) begin
      m_op = op_in; m_pc = pc_in;
      m_tag[0] = tagx_in; m_tag[1] = tagy_in; m_tag[2] = tagw_in;
      m_addr[0] = addrx_in; m_addr[1] = addry_in; m_addr[2] = addrw_in;
      m_val[0] = datax_in; m_val[1] = datay_in;
    end
    if (en_in || m_busy) begin
      for (int k = 0; k < 3; k++) begin
        if (m_tag[k] != '0 && m_addr[k] != '0) begin
          for (int s = 0; s < ns; s++) begin
            if (s_en[s] && s_a[s] == m_addr[k]) begin
              m_tag[k] = '0;
              if (k < 2) m_val[k] = s_d[s];
              break;
            end
          end
        end
      end
    end
    m_busy = en_in ? 1'b1 : (fire ? 1'b0 : m_busy);
  endtask

  task automatic rand_tag_addr(output logic [2:0] t, output logic [4:0] a);
    t = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
    a = (t != '0) ? 5'($urandom_range(1, 3)) : 5'($urandom_range(0, 3));
  endtask

  initial begin
    bit fire_now;
    n_checks = 0;
    n_errors = 0;
    vecs[0]  = '{4'd0,  32'h0,    32'd5,        32'd7,        32'd12,       5'd3};
    vecs[1]  = '{4'd0,  32'h0,    32'hFFFFFFFF, 32'd2,        32'd1,        5'd4};
    vecs[2]  = '{4'd1,  32'h0,    32'd3,        32'd5,        32'hFFFFFFFE, 5'd5};
    vecs[3]  = '{4'd2,  32'h0,    32'd1,        32'd31,       32'h80000000, 5'd6};
    vecs[4]  = '{4'd2,  32'h0,    32'd3,        32'd33,       32'd6,        5'd7};
    vecs[5]  = '{4'd3,  32'h0,    32'hFFFFFFFF, 32'd1,        32'd1,        5'd8};
    vecs[6]  = '{4'd4,  32'h0,    32'hFFFFFFFF, 32'd1,        32'd0,        5'd9};
    vecs[7]  = '{4'd5,  32'h0,    32'h0000F0F0, 32'h000000FF, 32'h0000F00F, 5'd10};
    vecs[8]  = '{4'd6,  32'h0,    32'h80000000, 32'd4,        32'h08000000, 5'd11};
    vecs[9]  = '{4'd7,  32'h0,    32'h80000000, 32'd4,        32'hF8000000, 5'd12};
    vecs[10] = '{4'd8,  32'h0,    32'h000000F0, 32'h0000000F, 32'h000000FF, 5'd13};
    vecs[11] = '{4'd9,  32'h0,    32'h000000F0, 32'h0000003C, 32'h00000030, 5'd14};
    vecs[12] = '{4'd10, 32'h0,    32'd77,       32'h12345000, 32'h12345000, 5'd15};
    vecs[13] = '{4'd11, 32'h1000, 32'd77,       32'h00002000, 32'h00003000, 5'd16};
    vecs[14] = '{4'd12, 32'h100,  32'd77,       32'd88,       32'h00000104, 5'd17};
    vecs[15] = '{4'd13, 32'h100,  32'd1,        32'd2,        32'd0,        5'd18};
    vecs[16] = '{4'd15, 32'h100,  32'd1,        32'd2,        32'd0,        5'd31};
    vecs[17] = '{4'd3,  32'h0,    32'd1,        32'hFFFFFFFF, 32'd0,        5'd19};

    rst = 1'b0;
    idle();
    tick(); tick();
    chk("reset_busy", 32'(busy_out), 32'd0);
    chk("reset_wb_en", 32'(wb_en_out), 32'd0);
    chk("reset_wb_addr", 32'(wb_addr_out), 32'd0);
    chk("reset_wb_data", wb_data_out, 32'd0);
    chk("reset_tags", 32'({tagx_out, tagy_out, tagw_out}), 32'd0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 18; i++) begin
      issue(vecs[i].op, vecs[i].pc, vecs[i].x, vecs[i].y, 3'd0, 3'd0, 3'd0, 5'd1, 5'd2, vecs[i].aw);
      tick(); idle();
      chk("vec_busy_after_accept", 32'(busy_out), 32'd1);
      chk("vec_no_early_wb", 32'(wb_en_out), 32'd0);
      tick();
      chk("vec_wb_en", 32'(wb_en_out), 32'd1);
      chk("vec_wb_addr", 32'(wb_addr_out), 32'(vecs[i].aw));
      chk("vec_wb_data", wb_data_out, vecs[i].exp);
      chk("vec_busy_clear", 32'(busy_out), 32'd0);
      tick();
      chk("vec_wb_one_cycle", 32'(wb_en_out), 32'd0);
    end

    // SUB waiting on x from mw1
    issue(4'd1, 32'h0, 32'd0, 32'd3, 3'd2, 3'd0, 3'd0, 5'd4, 5'd0, 5'd9);
    tick(); idle();
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("sub_hold_busy", 32'(busy_out), 32'd1);
      chk("sub_hold_no_wb", 32'(wb_en_out), 32'd0);
      chk("sub_hold_tagx", 32'(tagx_out), 32'd2);
    end
    en_mw1 = 1'b1; waddr1 = 5'd4; wdata1 = 32'd10;
    tick(); idle();
    chk("sub_tagx_released", 32'(tagx_out), 32'd0);
    tick();
    chk("sub_wb_en", 32'(wb_en_out), 32'd1);
    chk("sub_wb_data", wb_data_out, 32'd7);
    chk("sub_wb_addr", 32'(wb_addr_out), 32'd9);

    // accept-cycle snoop priority mw0 over mw2
    issue(4'd0, 32'h0, 32'd99, 32'd0, 3'd1, 3'd0, 3'd0, 5'd4, 5'd0, 5'd6);
    en_mw0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'd1;
    en_mw2 = 1'b1; waddr2 = 5'd4; wdata2 = 32'd9;
    tick(); idle();
    chk("prio_accept_tag", 32'(tagx_out), 32'd0);
    tick();
    chk("prio_accept_data", wb_data_out, 32'd1);
    // WAIT-state snoop priority mw1 over mw2
    issue(4'd0, 32'h0, 32'd0, 32'd0, 3'd0, 3'd3, 3'd0, 5'd0, 5'd2, 5'd6);
    tick(); idle();
    en_mw1 = 1'b1; waddr1 = 5'd2; wdata1 = 32'd40;
    en_mw2 = 1'b1; waddr2 = 5'd2; wdata2 = 32'd50;
    tick(); idle(); tick();
    chk("prio_wait_data", wb_data_out, 32'd40);

    // back-to-back fire with new accept
    issue(4'd4, 32'h0, 32'd1, 32'd2, 3'd0, 3'd0, 3'd0, 5'd0, 5'd0, 5'd5);
    tick();
    issue(4'd7, 32'h0, 32'h80000000, 32'd4, 3'd0, 3'd0, 3'd0, 5'd0, 5'd0, 5'd7);
    tick(); idle();
    chk("b2b_first_wb", wb_data_out, 32'd1);
    chk("b2b_first_en", 32'(wb_en_out), 32'd1);
    chk("b2b_busy_held", 32'(busy_out), 32'd1);
    tick();
    chk("b2b_second_wb", wb_data_out, 32'hF8000000);
    chk("b2b_second_addr", 32'(wb_addr_out), 32'd7);
    chk("b2b_busy_clear", 32'(busy_out), 32'd0);

    // rdy=0 freezes, en_in ignored
    issue(4'd0, 32'h0, 32'd3, 32'd4, 3'd0, 3'd0, 3'd0, 5'd0, 5'd0, 5'd2);
    tick();
    issue(4'd1, 32'h0, 32'd100, 32'd1, 3'd0, 3'd0, 3'd0, 5'd0, 5'd0, 5'd8);
    rdy = 1'b0;
    tick();
    chk("frz_busy", 32'(busy_out), 32'd1);
    chk("frz_no_wb", 32'(wb_en_out), 32'd0);
    tick();
    chk("frz_busy2", 32'(busy_out), 32'd1);
    idle();
    tick();
    chk("frz_wb_en", 32'(wb_en_out), 32'd1);
    chk("frz_wb_data", wb_data_out, 32'd7);
    chk("frz_wb_addr", 32'(wb_addr_out), 32'd2);
    chk("frz_busy_clear", 32'(busy_out), 32'd0);

    // addrw=0 suppresses broadcast
    issue(4'd0, 32'h0, 32'd1, 32'd1, 3'd0, 3'd0, 3'd0, 5'd0, 5'd0, 5'd0);
    tick(); idle(); tick();
    chk("aw0_busy", 32'(busy_out), 32'd0);
    chk("aw0_no_wb", 32'(wb_en_out), 32'd0);
    tick();
    chk("aw0_no_wb_later", 32'(wb_en_out), 32'd0);

    // dependent op on own result
    issue(4'd0, 32'h0, 32'd5, 32'd7, 3'd0, 3'd0, 3'd0, 5'd0, 5'd0, 5'd3);
    tick(); idle(); tick();
    chk("fwd_prod_wb", wb_data_out, 32'd12);
    chk("fwd_prod_addr", 32'(wb_addr_out), 32'd3);
    issue(4'd0, 32'h0, 32'd0, 32'd1, 3'd1, 3'd0, 3'd0, 5'd3, 5'd0, 5'd4);
    tick(); idle();
`ifdef ALU_SELF_FWD_EN
    chk("fwd_tagx", 32'(tagx_out), 32'd0);
    tick();
    chk("fwd_wb_en", 32'(wb_en_out), 32'd1);
    chk("fwd_wb_data", wb_data_out, 32'd13);
`else
    chk("nofwd_tagx", 32'(tagx_out), 32'd1);
    tick();
    chk("nofwd_busy", 32'(busy_out), 32'd1);
    chk("nofwd_no_wb", 32'(wb_en_out), 32'd0);
    en_mw0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'd20;
    tick(); idle(); tick();
    chk("nofwd_wb_en", 32'(wb_en_out), 32'd1);
    chk("nofwd_wb_data", wb_data_out, 32'd21);
`endif
    tick();

    // async reset mid-WAIT with a broadcast in flight; addr 0 never matches
    issue(4'd0, 32'h0, 32'd2, 32'd2, 3'd0, 3'd0, 3'd0, 5'd0, 5'd0, 5'd8);
    tick();
    issue(4'd1, 32'h0, 32'd0, 32'd0, 3'd2, 3'd0, 3'd0, 5'd0, 5'd0, 5'd9);
    en_mw0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'd55;
    tick(); idle();
    chk("rst_pre_wb_en", 32'(wb_en_out), 32'd1);
    chk("rst_pre_wb_data", wb_data_out, 32'd4);
    chk("rst_pre_busy", 32'(busy_out), 32'd1);
    chk("addr0_no_snoop", 32'(tagx_out), 32'd2);
    #2 rst = 1'b0;
    #1;
    chk("rst_async_busy", 32'(busy_out), 32'd0);
    chk("rst_async_wb_en", 32'(wb_en_out), 32'd0);
    chk("rst_async_wb_addr", 32'(wb_addr_out), 32'd0);
    chk("rst_async_wb_data", wb_data_out, 32'd0);
    chk("rst_async_tagx", 32'(tagx_out), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("rst_dropped_busy", 32'(busy_out), 32'd0);
    chk("rst_dropped_wb", 32'(wb_en_out), 32'd0);

    // randomized run against the model
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      fire_now = m_busy && m_tag[0] == '0 && m_tag[1] == '0 && m_tag[2] == '0;
      rdy = ($urandom_range(0, 7) != 0);
      en_in = (!m_busy || fire_now) && ($urandom_range(0, 1) == 1);
      op_in = 4'($urandom);
      pc_in = $urandom;
      datax_in = $urandom;
      datay_in = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : $urandom;
      rand_tag_addr(tagx_in, addrx_in);
      rand_tag_addr(tagy_in, addry_in);
      rand_tag_addr(tagw_in, addrw_in);
      en_mw0 = ($urandom_range(0, 2) == 0); waddr0 = 5'($urandom_range(0, 3)); wdata0 = $urandom;
      en_mw1 = ($urandom_range(0, 2) == 0); waddr1 = 5'($urandom_range(0, 3)); wdata1 = $urandom;
      en_mw2 = ($urandom_range(0, 2) == 0); waddr2 = 5'($urandom_range(0, 3)); wdata2 = $urandom;
      model_step();
      tick();
      chk("rnd_busy", 32'(busy_out), 32'(m_busy));
      chk("rnd_tags", 32'({tagx_out, tagy_out, tagw_out}), 32'({m_tag[0], m_tag[1], m_tag[2]}));
      chk("rnd_wb_en", 32'(wb_en_out), 32'(m_wb_en));
      chk("rnd_wb_addr", 32'(wb_addr_out), 32'(m_wb_addr));
      chk("rnd_wb_data", wb_data_out, m_wb_data);
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
